// File: rtl/sticky_capture_bank.sv
// sticky_capture_bank: multi-channel sticky event flags with saturating counters and a first-event recorder
module sticky_capture_bank #(
  parameter int CHANNELS = 4,
  parameter int CNT_WIDTH = 8,
  parameter int EDGE_MODE = 0,
  localparam int SW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CHANNELS-1:0]  b,
  input  logic [CHANNELS-1:0]  mask,
  input  logic [CHANNELS-1:0]  clr,
  input  logic [SW-1:0]        cnt_sel,
  output logic [CHANNELS-1:0]  a,
  output logic                 any_flag,
  output logic [CNT_WIDTH-1:0] cnt_out,
  output logic                 first_valid,
  output logic [SW-1:0]        first_id
);
  typedef enum logic {IDLE, HELD} state_t;
  state_t state, state_nxt;
  logic [CHANNELS-1:0] prev, ev, a_nxt;
  logic [CNT_WIDTH-1:0] cnt [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_nxt [CHANNELS];
  logic [SW-1:0] low_id, id_nxt;
  assign ev = b & ~mask & (EDGE_MODE != 0 ? ~prev : '1);
  // set wins over clear, so a simultaneous event keeps the flag up
  assign a_nxt = (a & ~clr) | ev;
  assign any_flag = |a;
  assign first_valid = state == HELD;
  assign cnt_out = 32'(cnt_sel) < CHANNELS ? cnt[cnt_sel] : '0;
  always_comb begin
    low_id = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) low_id = ev[i] ? SW'(i) : low_id;
    for (int i = 0; i < CHANNELS; i++)
      cnt_nxt[i] = ev[i] ? (clr[i] ? CNT_WIDTH'(1) : cnt[i] + CNT_WIDTH'(cnt[i] != '1)) : (clr[i] ? '0 : cnt[i]);
  end
  // release only when the post-update flag vector is empty; a same-cycle event keeps it non-empty
  always_comb begin
    state_nxt = state;
    id_nxt = first_id;
    if (state == IDLE && |ev) begin
      state_nxt = HELD;
      id_nxt = low_id;
    end else if (state == HELD && a_nxt == '0) begin
      state_nxt = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      first_id <= '0;
      a <= '0;
      prev <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
    end else begin
      state <= state_nxt;
      first_id <= id_nxt;
      a <= a_nxt;
      prev <= b;
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= cnt_nxt[i];
    end
  end
endmodule

// File: tb/tb_sticky_capture_bank.sv
// tb_sticky_capture_bank: level and edge instances against a flag/counter/recorder reference model
module tb_sticky_capture_bank;
  logic clk = 0, rst = 1;
  logic [3:0] b = 0, mask = 0, clr = 0;
  logic [1:0] cnt_sel = 0;
  logic [3:0] a_l, a_e, cnt_l, cnt_e;
  logic any_l, any_e, fv_l, fv_e;
  logic [1:0] fid_l, fid_e;
  int checks = 0, errors = 0;
  bit m_flag [2][4];
  int m_cnt [2][4];
  bit m_prev [4];
  bit m_fv [2];
  int m_fid [2];

  always #5 clk = ~clk;

  sticky_capture_bank #(.CHANNELS(4), .CNT_WIDTH(4), .EDGE_MODE(0)) u_lvl (
    .clk(clk), .rst(rst), .b(b), .mask(mask), .clr(clr), .cnt_sel(cnt_sel),
    .a(a_l), .any_flag(any_l), .cnt_out(cnt_l), .first_valid(fv_l), .first_id(fid_l));
  sticky_capture_bank #(.CHANNELS(4), .CNT_WIDTH(4), .EDGE_MODE(1)) u_edg (
    .clk(clk), .rst(rst), .b(b), .mask(mask), .clr(clr), .cnt_sel(cnt_sel),
    .a(a_e), .any_flag(any_e), .cnt_out(cnt_e), .first_valid(fv_e), .first_id(fid_e));

  function automatic logic [3:0] mflags(int d);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = m_flag[d][i];
    return r;
  endfunction

  // advance one clock and apply the same inputs to the reference model
  task automatic step();
    bit ev;
    int first;
    @(posedge clk);
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 4; i++) begin
          m_flag[d][i] = 0;
          m_cnt[d][i] = 0;
        end
        m_fv[d] = 0;
        m_fid[d] = 0;
      end
      for (int i = 0; i < 4; i++) m_prev[i] = 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        first = -1;
        for (int i = 0; i < 4; i++) begin
          ev = b[i] && !mask[i] && (d == 0 || !m_prev[i]);
          if (ev && first < 0) first = i;
          if (ev) begin
            m_flag[d][i] = 1;
            m_cnt[d][i] = clr[i] ? 1 : (m_cnt[d][i] < 15 ? m_cnt[d][i] + 1 : 15);
          end else if (clr[i]) begin
            m_flag[d][i] = 0;
            m_cnt[d][i] = 0;
          end
        end
        if (!m_fv[d] && first >= 0) begin
          m_fv[d] = 1;
          m_fid[d] = first;
        end else if (m_fv[d] && mflags(d) == 0) begin
          m_fv[d] = 0;
        end
      end
      for (int i = 0; i < 4; i++) m_prev[i] = b[i];
    end
    #1;
  endtask

  task automatic clear_all();
    b = 0; mask = 0; clr = 4'b1111;
    step();
    clr = 0;
  endtask

  task automatic test_reset();
    rst = 1; b = 4'($urandom); mask = 4'($urandom); clr = 4'($urandom);
    step();
    b = 4'b1111;
    step();
    rst = 0; b = 0; mask = 0; clr = 0;
    checks++; if (a_l !== 4'b0 || a_e !== 4'b0) begin errors++; $display("FAIL reset_a: got %b/%b expected 0000", a_l, a_e); end
    checks++; if (any_l !== 1'b0 || any_e !== 1'b0) begin errors++; $display("FAIL reset_any: got %b/%b expected 0", any_l, any_e); end
    checks++; if (fv_l !== 1'b0 || fv_e !== 1'b0 || fid_l !== 2'd0 || fid_e !== 2'd0) begin errors++; $display("FAIL reset_first: got v=%b/%b id=%0d/%0d expected 0", fv_l, fv_e, fid_l, fid_e); end
    for (int s = 0; s < 4; s++) begin
      cnt_sel = 2'(s); #1;
      checks++; if (cnt_l !== 4'd0 || cnt_e !== 4'd0) begin errors++; $display("FAIL reset_cnt%0d: got %0d/%0d expected 0", s, cnt_l, cnt_e); end
    end
  endtask

  task automatic test_level();
    cnt_sel = 2; b = 4'b0100;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++; if (a_l !== 4'b0100) begin errors++; $display("FAIL level_a: got %b expected 0100", a_l); end
      checks++; if (int'(cnt_l) !== k) begin errors++; $display("FAIL level_cnt: got %0d expected %0d", cnt_l, k); end
    end
    b = 0;
    step(); step();
    checks++; if (a_l !== 4'b0100 || any_l !== 1'b1) begin errors++; $display("FAIL level_hold: got a=%b any=%b expected 0100 1", a_l, any_l); end
    checks++; if (cnt_l !== 4'd3) begin errors++; $display("FAIL level_cnt_final: got %0d expected 3", cnt_l); end
    checks++; if (fv_l !== 1'b1 || fid_l !== 2'd2) begin errors++; $display("FAIL level_first: got v=%b id=%0d expected 1 2", fv_l, fid_l); end
    checks++; if (cnt_e !== 4'd1) begin errors++; $display("FAIL edge_after_reset: got %0d expected 1", cnt_e); end
  endtask

  task automatic test_edge();
    clear_all();
    cnt_sel = 1; b = 4'b0010;
    repeat (5) step();
    b = 0;
    repeat (2) step();
    b = 4'b0010;
    step();
    b = 0;
    step();
    checks++; if (cnt_e !== 4'd2) begin errors++; $display("FAIL edge_cnt: got %0d expected 2", cnt_e); end
    checks++; if (a_e[1] !== 1'b1) begin errors++; $display("FAIL edge_flag: got %b expected 1", a_e[1]); end
    checks++; if (cnt_l !== 4'd6) begin errors++; $display("FAIL edge_level_cnt: got %0d expected 6", cnt_l); end
  endtask

  task automatic test_setclr();
    clear_all();
    step();
    checks++; if (fv_l !== 1'b0) begin errors++; $display("FAIL setclr_idle: got %b expected 0", fv_l); end
    cnt_sel = 1; b = 4'b1010; clr = 4'b0010;
    step();
    checks++; if (a_l !== 4'b1010 || a_e !== 4'b1010) begin errors++; $display("FAIL setclr_a: got %b/%b expected 1010", a_l, a_e); end
    checks++; if (cnt_l !== 4'd1 || cnt_e !== 4'd1) begin errors++; $display("FAIL setclr_cnt: got %0d/%0d expected 1", cnt_l, cnt_e); end
    checks++; if (fv_l !== 1'b1 || fid_l !== 2'd1) begin errors++; $display("FAIL setclr_tie: got v=%b id=%0d expected 1 1", fv_l, fid_l); end
    b = 4'b0010;
    step();
    checks++; if (cnt_l !== 4'd1 || a_l !== 4'b1010) begin errors++; $display("FAIL setclr_again_lvl: got cnt=%0d a=%b expected 1 1010", cnt_l, a_l); end
    checks++; if (cnt_e !== 4'd0 || a_e !== 4'b1000) begin errors++; $display("FAIL setclr_again_edge: got cnt=%0d a=%b expected 0 1000", cnt_e, a_e); end
    b = 0; clr = 0;
  endtask

  task automatic test_saturation();
    clear_all();
    cnt_sel = 0; b = 4'b0001;
    for (int k = 1; k <= 20; k++) begin
      step();
      checks++; if (int'(cnt_l) !== (k < 15 ? k : 15)) begin errors++; $display("FAIL sat_cnt%0d: got %0d expected %0d", k, cnt_l, k < 15 ? k : 15); end
    end
    checks++; if (cnt_e !== 4'd1) begin errors++; $display("FAIL sat_edge: got %0d expected 1", cnt_e); end
    b = 0;
  endtask

  task automatic test_mask();
    clear_all();
    cnt_sel = 0; mask = 4'b0001; b = 4'b0001;
    repeat (3) begin
      step();
      checks++; if (a_l !== 4'b0 || cnt_l !== 4'd0 || fv_l !== 1'b0) begin errors++; $display("FAIL mask_block: got a=%b cnt=%0d v=%b expected 0", a_l, cnt_l, fv_l); end
    end
    mask = 0; b = 4'b1000;
    step();
    checks++; if (a_l !== 4'b1000 || fv_l !== 1'b1 || fid_l !== 2'd3) begin errors++; $display("FAIL mask_pulse: got a=%b v=%b id=%0d expected 1000 1 3", a_l, fv_l, fid_l); end
    cnt_sel = 2; b = 4'b0100;
    step();
    mask = 4'b0100;
    step();
    checks++; if (a_l !== 4'b1100 || cnt_l !== 4'd1) begin errors++; $display("FAIL mask_keep: got a=%b cnt=%0d expected 1100 1", a_l, cnt_l); end
    mask = 0; b = 0; clr = 4'b1111;
    step();
    clr = 0;
    checks++; if (a_l !== 4'b0 || fv_l !== 1'b0 || any_l !== 1'b0) begin errors++; $display("FAIL mask_release: got a=%b v=%b any=%b expected 0", a_l, fv_l, any_l); end
  endtask

  task automatic test_rst_mid();
    clear_all();
    cnt_sel = 1; b = 4'b0110;
    step();
    b = 4'b0010;
    repeat (4) step();
    checks++; if (cnt_l !== 4'd5 || a_l !== 4'b0110 || fv_l !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got cnt=%0d a=%b v=%b expected 5 0110 1", cnt_l, a_l, fv_l); end
    rst = 1; b = 4'b1111;
    step();
    rst = 0; b = 0;
    checks++; if (a_l !== 4'b0 || a_e !== 4'b0 || any_l !== 1'b0 || any_e !== 1'b0) begin errors++; $display("FAIL rstmid_a: got %b/%b expected 0000", a_l, a_e); end
    checks++; if (fv_l !== 1'b0 || fv_e !== 1'b0 || fid_l !== 2'd0) begin errors++; $display("FAIL rstmid_first: got v=%b/%b id=%0d expected 0", fv_l, fv_e, fid_l); end
    checks++; if (cnt_l !== 4'd0 || cnt_e !== 4'd0) begin errors++; $display("FAIL rstmid_cnt: got %0d/%0d expected 0", cnt_l, cnt_e); end
  endtask

  task automatic test_random();
    logic [3:0] ga, gc;
    logic gany, gv;
    logic [1:0] gid;
    for (int n = 0; n < 400; n++) begin
      rst = $urandom_range(0, 49) == 0;
      b = 4'($urandom);
      mask = 4'($urandom & $urandom);
      clr = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'b0;
      step();
      cnt_sel = 2'($urandom);
      #1;
      for (int d = 0; d < 2; d++) begin
        ga = d == 0 ? a_l : a_e;
        gc = d == 0 ? cnt_l : cnt_e;
        gany = d == 0 ? any_l : any_e;
        gv = d == 0 ? fv_l : fv_e;
        gid = d == 0 ? fid_l : fid_e;
        checks++; if (ga !== mflags(d) || gany !== (mflags(d) != 0)) begin errors++; $display("FAIL rand_a d%0d n%0d: got %b any=%b expected %b", d, n, ga, gany, mflags(d)); end
        checks++; if (int'(gc) !== m_cnt[d][cnt_sel]) begin errors++; $display("FAIL rand_cnt d%0d n%0d: got %0d expected %0d", d, n, gc, m_cnt[d][cnt_sel]); end
        checks++; if (gv !== m_fv[d] || (m_fv[d] && int'(gid) !== m_fid[d])) begin errors++; $display("FAIL rand_first d%0d n%0d: got v=%b id=%0d expected v=%b id=%0d", d, n, gv, gid, m_fv[d], m_fid[d]); end
      end
    end
    rst = 0; b = 0; mask = 0; clr = 0;
  endtask

  initial begin
    test_reset();
    test_level();
    test_edge();
    test_setclr();
    test_saturation();
    test_mask();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
